// File: rtl/kgd_fill_master.sv
// -----------------------------------------------------------------------------
// kgd_fill_master
//
// Second Wishbone initiator on the KGD side of the bus arbiter. It fills or
// verifies a run of video-RAM bytes through the KGD register window
// (ctrl +0, data +2, addr +4). For every byte it first writes the addr
// register, then either writes the data register (fill) or reads it back and
// compares against the expected byte (verify). An optional ctrl-register write
// ({g_on=1, t_off, 14'b0}) can precede the byte run.
//
// Ports
//   wb_clk_i, wb_rst_i    bus clock, asynchronous active-high reset
//   cmd_start             1-cycle start pulse, honoured only while idle
//   cmd_verify            0 = fill, 1 = verify
//   cmd_gon, cmd_toff     issue the ctrl write first / t_off value for it
//   cmd_addr, cmd_len     first video-RAM address / byte count (0 = no bytes)
//   cmd_data              fill pattern or expected byte
//   cmd_abort             finish after the bus cycle currently in flight
//   busy, done, err       in progress / 1-cycle end pulse / sticky timeout
//   mism_cnt, cur_addr    saturating verify miss count / current address
//   wbm_*                 Wishbone master port towards the KGD
// -----------------------------------------------------------------------------
module kgd_fill_master #(
    parameter int TIMEOUT = 64
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_start,
    input  logic        cmd_verify,
    input  logic        cmd_gon,
    input  logic        cmd_toff,
    input  logic [13:0] cmd_addr,
    input  logic [13:0] cmd_len,
    input  logic [7:0]  cmd_data,
    input  logic        cmd_abort,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [13:0] mism_cnt,
    output logic [13:0] cur_addr,
    output logic [2:0]  wbm_adr_o,
    output logic [15:0] wbm_dat_o,
    input  logic [15:0] wbm_dat_i,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [1:0]  wbm_sel_o,
    input  logic        wbm_ack_i
);

    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CTRL,
        S_ADDR,
        S_DATA,
        S_GAP,
        S_FIN
    } state_t;

    state_t         state;
    state_t         gap_next;
    logic           verify_q;
    logic           toff_q;
    logic [7:0]     data_q;
    logic [13:0]    remaining;
    logic           abort_pend;
    logic [WW-1:0]  wait_cnt;
    logic           abort_now;
    logic           unused_dat_hi;

    // An abort arriving in the same cycle as an ack must still stop the run.
    assign abort_now = abort_pend | cmd_abort;

    // Only the low byte of read data carries video-RAM contents.
    assign unused_dat_hi = ^wbm_dat_i[15:8];

    // Single sequencer. Every bus access is a CTRL/ADDR/DATA state entered
    // from GAP; GAP both supplies the mandatory idle cycle between accesses
    // and waits out the KGD's two-cycle ack so a stale ack is never taken as
    // the response to a new access.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= S_IDLE;
            gap_next   <= S_ADDR;
            verify_q   <= 1'b0;
            toff_q     <= 1'b0;
            data_q     <= 8'h00;
            remaining  <= 14'd0;
            abort_pend <= 1'b0;
            wait_cnt   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            mism_cnt   <= 14'd0;
            cur_addr   <= 14'd0;
            wbm_adr_o  <= 3'b000;
            wbm_dat_o  <= 16'h0000;
            wbm_cyc_o  <= 1'b0;
            wbm_stb_o  <= 1'b0;
            wbm_we_o   <= 1'b0;
            wbm_sel_o  <= 2'b00;
        end else begin
            done <= 1'b0;
            if (state != S_IDLE && cmd_abort) begin
                abort_pend <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (cmd_start) begin
                        verify_q   <= cmd_verify;
                        toff_q     <= cmd_toff;
                        data_q     <= cmd_data;
                        remaining  <= cmd_len;
                        cur_addr   <= cmd_addr;
                        busy       <= 1'b1;
                        err        <= 1'b0;
                        mism_cnt   <= 14'd0;
                        abort_pend <= 1'b0;
                        gap_next   <= cmd_gon ? S_CTRL : S_ADDR;
                        state      <= (cmd_len == 14'd0 && !cmd_gon) ? S_FIN : S_GAP;
                    end
                end

                S_GAP: begin
                    if (abort_now) begin
                        state <= S_FIN;
                    end else if (!wbm_ack_i) begin
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wait_cnt  <= '0;
                        state     <= gap_next;
                        case (gap_next)
                            S_CTRL: begin
                                wbm_adr_o <= 3'b000;
                                wbm_we_o  <= 1'b1;
                                wbm_sel_o <= 2'b10;
                                wbm_dat_o <= {1'b1, toff_q, 14'b0};
                            end
                            S_ADDR: begin
                                wbm_adr_o <= 3'b100;
                                wbm_we_o  <= 1'b1;
                                wbm_sel_o <= 2'b11;
                                wbm_dat_o <= {2'b00, cur_addr};
                            end
                            default: begin
                                wbm_adr_o <= 3'b010;
                                wbm_we_o  <= !verify_q;
                                wbm_sel_o <= verify_q ? 2'b11 : 2'b01;
                                wbm_dat_o <= verify_q ? 16'h0000 : {8'h00, data_q};
                            end
                        endcase
                    end
                end

                S_CTRL, S_ADDR, S_DATA: begin
                    if (wbm_ack_i) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        case (state)
                            S_CTRL: begin
                                if (remaining == 14'd0 || abort_now) begin
                                    state <= S_FIN;
                                end else begin
                                    gap_next <= S_ADDR;
                                    state    <= S_GAP;
                                end
                            end
                            S_ADDR: begin
                                if (abort_now) begin
                                    state <= S_FIN;
                                end else begin
                                    gap_next <= S_DATA;
                                    state    <= S_GAP;
                                end
                            end
                            S_DATA: begin
                                if (verify_q && wbm_dat_i[7:0] != data_q && mism_cnt != 14'h3FFF) begin
                                    mism_cnt <= mism_cnt + 14'd1;
                                end
                                cur_addr  <= cur_addr + 14'd1;
                                remaining <= remaining - 14'd1;
                                if (remaining == 14'd1 || abort_now) begin
                                    state <= S_FIN;
                                end else begin
                                    gap_next <= S_ADDR;
                                    state    <= S_GAP;
                                end
                            end
                            default: state <= S_FIN;
                        endcase
                    end else if (wait_cnt == WAIT_LAST) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        err       <= 1'b1;
                        state     <= S_FIN;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                S_FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kgd_fill_master.sv
// -----------------------------------------------------------------------------
// tb_kgd_fill_master
//
// Drives kgd_fill_master against a behavioural KGD slave (register window plus
// 16 KiB video RAM, two-cycle ack) and compares bus traffic, RAM contents and
// status outputs with a command-level reference model.
// -----------------------------------------------------------------------------
module tb_kgd_fill_master;

    localparam int TIMEOUT = 64;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        cmd_start = 1'b0;
    logic        cmd_verify = 1'b0;
    logic        cmd_gon = 1'b0;
    logic        cmd_toff = 1'b0;
    logic [13:0] cmd_addr = 14'd0;
    logic [13:0] cmd_len = 14'd0;
    logic [7:0]  cmd_data = 8'h00;
    logic        cmd_abort = 1'b0;
    logic        busy, done, err;
    logic [13:0] mism_cnt, cur_addr;
    logic [2:0]  wbm_adr_o;
    logic [15:0] wbm_dat_o;
    logic [15:0] wbm_dat_i = 16'h0000;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [1:0]  wbm_sel_o;
    logic        wbm_ack_i = 1'b0;

    kgd_fill_master #(.TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .cmd_start (cmd_start),
        .cmd_verify(cmd_verify),
        .cmd_gon   (cmd_gon),
        .cmd_toff  (cmd_toff),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .cmd_abort (cmd_abort),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mism_cnt  (mism_cnt),
        .cur_addr  (cur_addr),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_ack_i (wbm_ack_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct packed {
        logic        we;
        logic [2:0]  adr;
        logic [15:0] dat;
        logic [1:0]  sel;
    } txn_t;

    function automatic txn_t mk(input logic we, input logic [2:0] adr, input logic [15:0] dat, input logic [1:0] sel);
        txn_t t;
        t.we = we; t.adr = adr; t.dat = dat; t.sel = sel;
        return t;
    endfunction

    // Slave side state (owned by the slave/monitor processes)
    logic [7:0]  ram [0:16383];
    logic [13:0] kaddr = 14'd0;
    logic [15:0] kctrl = 16'h0000;
    logic [1:0]  ack_phase = 2'd0;
    logic        slave_en = 1'b1;
    logic        bd_we = 1'b0;
    logic [13:0] bd_addr = 14'd0;
    logic [7:0]  bd_dat = 8'h00;
    txn_t        seen_q[$];
    int          done_cnt = 0;
    int          cyc_cycles = 0;
    int          stb_bad = 0;

    // Reference model state (owned by the stimulus process)
    logic [7:0]  mram [0:16383];
    txn_t        exp_q[$];
    int          exp_mism;
    logic [13:0] exp_cur;

    int n_checks = 0;
    int n_pass = 0;

    // KGD slave: one access per strobe, ack held high for two cycles.
    always @(posedge wb_clk_i) begin
        if (bd_we) ram[bd_addr] <= bd_dat;
        if (wb_rst_i) begin
            wbm_ack_i <= 1'b0;
            ack_phase <= 2'd0;
        end else if (ack_phase == 2'd1) begin
            wbm_ack_i <= 1'b1;
            ack_phase <= 2'd2;
        end else if (ack_phase == 2'd2) begin
            wbm_ack_i <= 1'b0;
            ack_phase <= 2'd0;
        end else if (wbm_cyc_o && wbm_stb_o && slave_en) begin
            seen_q.push_back(mk(wbm_we_o, wbm_adr_o, wbm_we_o ? wbm_dat_o : 16'h0000, wbm_sel_o));
            case (wbm_adr_o)
                3'b100: kaddr <= wbm_dat_o[13:0];
                3'b000: kctrl <= wbm_dat_o;
                3'b010: begin
                    if (wbm_we_o) ram[kaddr] <= wbm_dat_o[7:0];
                    else wbm_dat_i <= {8'h00, ram[kaddr]};
                end
                default: ;
            endcase
            wbm_ack_i <= 1'b1;
            ack_phase <= 2'd1;
        end else begin
            wbm_ack_i <= 1'b0;
        end
    end

    // Activity counters sampled mid-cycle.
    always @(negedge wb_clk_i) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (wbm_cyc_o === 1'b1) cyc_cycles <= cyc_cycles + 1;
        if (wbm_stb_o !== wbm_cyc_o) stb_bad <= stb_bad + 1;
    end

    // Command-level model: expected bus accesses, miss count and final address.
    task automatic model_cmd(input logic [13:0] a0, input int len, input logic [7:0] d,
                             input logic ver, input logic gon, input logic toff);
        logic [13:0] a;
        exp_q.delete();
        exp_mism = 0;
        if (gon) exp_q.push_back(mk(1'b1, 3'b000, {1'b1, toff, 14'b0}, 2'b10));
        for (int i = 0; i < len; i++) begin
            a = 14'((int'(a0) + i) % 16384);
            exp_q.push_back(mk(1'b1, 3'b100, {2'b00, a}, 2'b11));
            if (ver) begin
                exp_q.push_back(mk(1'b0, 3'b010, 16'h0000, 2'b11));
                if (mram[a] !== d) exp_mism++;
            end else begin
                exp_q.push_back(mk(1'b1, 3'b010, {8'h00, d}, 2'b01));
                mram[a] = d;
            end
        end
        exp_cur = 14'((int'(a0) + len) % 16384);
    endtask

    function automatic int txn_diffs(input int q0);
        int n = 0;
        if (seen_q.size() - q0 != exp_q.size()) return 1000 + seen_q.size() - q0;
        for (int i = 0; i < exp_q.size(); i++)
            if (seen_q[q0 + i] !== exp_q[i]) n++;
        return n;
    endfunction

    function automatic int ram_diffs(input logic [13:0] a0, input int len);
        int n = 0;
        logic [13:0] a;
        for (int i = 0; i < len; i++) begin
            a = 14'((int'(a0) + i) % 16384);
            if (ram[a] !== mram[a]) n++;
        end
        return n;
    endfunction

    task automatic load_byte(input logic [13:0] a, input logic [7:0] v);
        @(negedge wb_clk_i);
        bd_addr = a; bd_dat = v; bd_we = 1'b1;
        mram[a] = v;
        @(negedge wb_clk_i);
        bd_we = 1'b0;
    endtask

    task automatic issue_cmd(input logic [13:0] a, input logic [13:0] l, input logic [7:0] d,
                             input logic v, input logic g, input logic t);
        @(negedge wb_clk_i);
        cmd_addr = a; cmd_len = l; cmd_data = d;
        cmd_verify = v; cmd_gon = g; cmd_toff = t;
        cmd_start = 1'b1;
        @(negedge wb_clk_i);
        cmd_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge wb_clk_i);
            if (done === 1'b1) got = 1'b1;
        end
        repeat (3) @(negedge wb_clk_i);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge wb_clk_i);
        n_checks++;
        if ({busy, done, err, wbm_cyc_o, wbm_stb_o, wbm_we_o} !== 6'b0)
            $display("[TB] FAIL reset_flags: got %b expected 000000", {busy, done, err, wbm_cyc_o, wbm_stb_o, wbm_we_o});
        else n_pass++;
        n_checks++;
        if ({mism_cnt, cur_addr, wbm_adr_o, wbm_dat_o, wbm_sel_o} !== 49'b0)
            $display("[TB] FAIL reset_values: mism=%0d cur=%0d adr=%0d dat=%h sel=%b expected all 0",
                     mism_cnt, cur_addr, wbm_adr_o, wbm_dat_o, wbm_sel_o);
        else n_pass++;
        wb_rst_i = 1'b0;
        repeat (2) @(negedge wb_clk_i);
        n_checks++;
        if ({busy, wbm_cyc_o} !== 2'b00)
            $display("[TB] FAIL idle_after_reset: busy/cyc=%b expected 00", {busy, wbm_cyc_o});
        else n_pass++;
    endtask

    task automatic test_fill();
        int q0, d0; bit got;
        q0 = seen_q.size(); d0 = done_cnt;
        model_cmd(14'd100, 3, 8'hA5, 1'b0, 1'b0, 1'b0);
        issue_cmd(14'd100, 14'd3, 8'hA5, 1'b0, 1'b0, 1'b0);
        wait_done(100, got);
        n_checks++;
        if (!got || done_cnt - d0 != 1) $display("[TB] FAIL fill_done: seen=%0d pulses=%0d expected 1 pulse", got, done_cnt - d0);
        else n_pass++;
        n_checks++;
        if (txn_diffs(q0) != 0) $display("[TB] FAIL fill_bus: %0d access differences, expected 0", txn_diffs(q0));
        else n_pass++;
        n_checks++;
        if (ram[100] !== 8'hA5 || ram[101] !== 8'hA5 || ram[102] !== 8'hA5)
            $display("[TB] FAIL fill_ram: got %h %h %h expected a5 a5 a5", ram[100], ram[101], ram[102]);
        else n_pass++;
        n_checks++;
        if (err !== 1'b0 || cur_addr !== 14'd103 || busy !== 1'b0)
            $display("[TB] FAIL fill_status: err=%b cur=%0d busy=%b expected 0 103 0", err, cur_addr, busy);
        else n_pass++;
    endtask

    task automatic test_verify();
        int q0; bit got;
        load_byte(14'd101, 8'h5A);
        q0 = seen_q.size();
        model_cmd(14'd100, 3, 8'hA5, 1'b1, 1'b0, 1'b0);
        issue_cmd(14'd100, 14'd3, 8'hA5, 1'b1, 1'b0, 1'b0);
        wait_done(100, got);
        n_checks++;
        if (!got || mism_cnt !== 14'd1) $display("[TB] FAIL verify_mism: done=%0d mism=%0d expected 1", got, mism_cnt);
        else n_pass++;
        n_checks++;
        if (seen_q.size() - q0 != 6 || txn_diffs(q0) != 0)
            $display("[TB] FAIL verify_bus: %0d accesses, %0d differences, expected 6 and 0", seen_q.size() - q0, txn_diffs(q0));
        else n_pass++;
        n_checks++;
        if (ram_diffs(14'd100, 3) != 0) $display("[TB] FAIL verify_ram_untouched: %0d bytes changed", ram_diffs(14'd100, 3));
        else n_pass++;
    endtask

    task automatic test_ctrl_only();
        int q0; bit got;
        q0 = seen_q.size();
        issue_cmd(14'd7, 14'd0, 8'h00, 1'b0, 1'b1, 1'b1);
        wait_done(40, got);
        n_checks++;
        if (!got || seen_q.size() - q0 != 1 || seen_q[seen_q.size() - 1] !== mk(1'b1, 3'b000, 16'hC000, 2'b10))
            $display("[TB] FAIL ctrl_write: done=%0d accesses=%0d expected one write adr 0 sel 10 dat c000", got, seen_q.size() - q0);
        else n_pass++;
        n_checks++;
        if (kctrl !== 16'hC000) $display("[TB] FAIL ctrl_reg: got %h expected c000", kctrl);
        else n_pass++;
    endtask

    task automatic test_zero_len();
        int q0, c0; bit got;
        q0 = seen_q.size(); c0 = cyc_cycles;
        issue_cmd(14'd55, 14'd0, 8'h11, 1'b0, 1'b0, 1'b0);
        wait_done(3, got);
        n_checks++;
        if (!got || cyc_cycles != c0 || seen_q.size() != q0)
            $display("[TB] FAIL zero_len: done=%0d cyc_cycles=%0d accesses=%0d expected 1 0 0", got, cyc_cycles - c0, seen_q.size() - q0);
        else n_pass++;
    endtask

    task automatic test_wrap();
        int q0; bit got;
        logic [7:0] d;
        d = 8'($urandom);
        q0 = seen_q.size();
        model_cmd(14'd16383, 2, d, 1'b0, 1'b0, 1'b0);
        issue_cmd(14'd16383, 14'd2, d, 1'b0, 1'b0, 1'b0);
        wait_done(100, got);
        n_checks++;
        if (!got || txn_diffs(q0) != 0) $display("[TB] FAIL wrap_bus: done=%0d differences=%0d expected 1 0", got, txn_diffs(q0));
        else n_pass++;
        n_checks++;
        if (cur_addr !== 14'd1) $display("[TB] FAIL wrap_cur_addr: got %0d expected 1", cur_addr);
        else n_pass++;
    endtask

    task automatic test_random();
        int q0, bad_bus, bad_stat, bad_ram; bit got;
        logic [13:0] a; int len; logic [7:0] d; logic v, g, t;
        bad_bus = 0; bad_stat = 0; bad_ram = 0;
        for (int n = 0; n < 20; n++) begin
            a = 14'($urandom_range(0, 16383));
            len = $urandom_range(1, 5);
            d = 8'($urandom);
            v = 1'($urandom_range(0, 1));
            g = 1'($urandom_range(0, 1));
            t = 1'($urandom_range(0, 1));
            if (v) begin
                for (int i = 0; i < len; i++)
                    load_byte(14'((int'(a) + i) % 16384), ($urandom_range(0, 1) == 1) ? d : 8'($urandom));
            end
            q0 = seen_q.size();
            model_cmd(a, len, d, v, g, t);
            issue_cmd(a, 14'(len), d, v, g, t);
            wait_done(120, got);
            if (txn_diffs(q0) != 0) bad_bus++;
            if (!got || int'(mism_cnt) != exp_mism || cur_addr !== exp_cur || err !== 1'b0) bad_stat++;
            if (ram_diffs(a, len) != 0) bad_ram++;
        end
        n_checks++;
        if (bad_bus != 0) $display("[TB] FAIL random_bus: %0d commands with wrong traffic, expected 0", bad_bus);
        else n_pass++;
        n_checks++;
        if (bad_stat != 0) $display("[TB] FAIL random_status: %0d commands with wrong status, expected 0", bad_stat);
        else n_pass++;
        n_checks++;
        if (bad_ram != 0) $display("[TB] FAIL random_ram: %0d commands with wrong RAM, expected 0", bad_ram);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int c0, d0; bit got;
        slave_en = 1'b0;
        c0 = cyc_cycles; d0 = done_cnt;
        issue_cmd(14'd500, 14'd2, 8'h33, 1'b0, 1'b0, 1'b0);
        wait_done(TIMEOUT + 20, got);
        n_checks++;
        if (cyc_cycles - c0 != TIMEOUT) $display("[TB] FAIL timeout_len: cyc high %0d cycles, expected %0d", cyc_cycles - c0, TIMEOUT);
        else n_pass++;
        n_checks++;
        if (!got || done_cnt - d0 != 1 || err !== 1'b1 || busy !== 1'b0)
            $display("[TB] FAIL timeout_status: done=%0d pulses=%0d err=%b busy=%b expected 1 1 1 0", got, done_cnt - d0, err, busy);
        else n_pass++;
        slave_en = 1'b1;
        issue_cmd(14'd0, 14'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (err !== 1'b0) $display("[TB] FAIL err_clear: got %b expected 0", err);
        else n_pass++;
        wait_done(5, got);
    endtask

    task automatic test_abort();
        int q0, d0, k; bit got, prev, cur;
        logic [13:0] a;
        a = 14'($urandom_range(1000, 2000));
        q0 = seen_q.size(); d0 = done_cnt;
        model_cmd(a, 2, 8'h77, 1'b0, 1'b0, 1'b0);
        issue_cmd(a, 14'd10, 8'h77, 1'b0, 1'b0, 1'b0);
        k = 0; prev = 1'b0;
        for (int i = 0; i < 300 && k < 2; i++) begin
            @(negedge wb_clk_i);
            cur = wbm_cyc_o && (wbm_adr_o == 3'b010);
            if (cur && !prev) k++;
            prev = cur;
        end
        cmd_abort = 1'b1;
        @(negedge wb_clk_i);
        cmd_abort = 1'b0;
        wait_done(60, got);
        n_checks++;
        if (k != 2 || !got || done_cnt - d0 != 1)
            $display("[TB] FAIL abort_done: data_cycles=%0d done=%0d pulses=%0d expected 2 1 1", k, got, done_cnt - d0);
        else n_pass++;
        n_checks++;
        if (cur_addr !== exp_cur || txn_diffs(q0) != 0 || ram_diffs(a, 2) != 0)
            $display("[TB] FAIL abort_result: cur=%0d expected %0d, bus differences=%0d", cur_addr, exp_cur, txn_diffs(q0));
        else n_pass++;
        // Abort while idle must not affect the next command.
        @(negedge wb_clk_i);
        cmd_abort = 1'b1;
        @(negedge wb_clk_i);
        cmd_abort = 1'b0;
        q0 = seen_q.size();
        model_cmd(14'd40, 2, 8'h0F, 1'b0, 1'b0, 1'b0);
        issue_cmd(14'd40, 14'd2, 8'h0F, 1'b0, 1'b0, 1'b0);
        wait_done(60, got);
        n_checks++;
        if (!got || cur_addr !== 14'd42 || txn_diffs(q0) != 0)
            $display("[TB] FAIL idle_abort_ignored: cur=%0d expected 42, differences=%0d", cur_addr, txn_diffs(q0));
        else n_pass++;
    endtask

    task automatic test_start_ignored();
        int q0, d0; bit got;
        q0 = seen_q.size(); d0 = done_cnt;
        model_cmd(14'd200, 3, 8'h3C, 1'b0, 1'b0, 1'b0);
        issue_cmd(14'd200, 14'd3, 8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (5) @(negedge wb_clk_i);
        issue_cmd(14'd900, 14'd1, 8'hFF, 1'b1, 1'b1, 1'b0);
        wait_done(100, got);
        repeat (10) @(negedge wb_clk_i);
        n_checks++;
        if (!got || done_cnt - d0 != 1 || cur_addr !== 14'd203 || txn_diffs(q0) != 0)
            $display("[TB] FAIL start_while_busy: pulses=%0d cur=%0d differences=%0d expected 1 203 0",
                     done_cnt - d0, cur_addr, txn_diffs(q0));
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int d0, i;
        d0 = done_cnt;
        issue_cmd(14'd3000, 14'd5, 8'h99, 1'b0, 1'b0, 1'b0);
        i = 0;
        while (wbm_cyc_o !== 1'b1 && i < 20) begin
            @(negedge wb_clk_i);
            i++;
        end
        n_checks++;
        if (wbm_cyc_o !== 1'b1) $display("[TB] FAIL reset_mid_setup: cyc=%b expected 1", wbm_cyc_o);
        else n_pass++;
        wb_rst_i = 1'b1;
        #1;
        n_checks++;
        if ({wbm_cyc_o, wbm_stb_o, busy} !== 3'b000)
            $display("[TB] FAIL reset_mid_drop: cyc/stb/busy=%b expected 000", {wbm_cyc_o, wbm_stb_o, busy});
        else n_pass++;
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        repeat (10) @(negedge wb_clk_i);
        n_checks++;
        if (done_cnt != d0 || busy !== 1'b0) $display("[TB] FAIL reset_mid_no_done: pulses=%0d busy=%b expected 0 0", done_cnt - d0, busy);
        else n_pass++;
    endtask

    // Scenario sequence, finishing with the strobe/cycle tie check.
    initial begin
        $display("[TB] start");
        test_reset();
        test_fill();
        test_verify();
        test_ctrl_only();
        test_zero_len();
        test_wrap();
        test_random();
        test_timeout();
        test_abort();
        test_start_ignored();
        test_reset_mid();
        n_checks++;
        if (stb_bad != 0) $display("[TB] FAIL stb_eq_cyc: %0d cycles with stb != cyc, expected 0", stb_bad);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
